// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit with HI/LO result registers.
// Multiplication is shift-add and division is restoring. Both work on operand
// magnitudes, one iteration per clock. Sign correction is applied on the last
// iteration, and HI/LO are written one cycle later, when the done pulse fires.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;      // partial product high half / partial remainder
    logic [WIDTH-1:0] mq_q;       // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] opnd_q;     // multiplicand or divisor magnitude
    logic             is_div_q;
    logic             neg_lo_q;   // negate product or quotient
    logic             neg_hi_q;   // negate remainder
    logic             zero_q;     // FIN reached through division by zero
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // Operand decode for a request presented in IDLE
    logic             op_signed;
    logic             op_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             start_div0;

    // Operand sign handling and the divide-by-zero shortcut decision
    always_comb begin
        op_signed  = ~op_i[0];
        op_div     = op_i[1];
        a_neg      = op_signed & a_i[WIDTH-1];
        b_neg      = op_signed & b_i[WIDTH-1];
        a_mag      = a_neg ? (-a_i) : a_i;
        b_mag      = b_neg ? (-b_i) : b_i;
        start_div0 = op_div && (b_i == '0);
    end

    // One iteration of either algorithm, plus final sign correction
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_acc;
    logic [WIDTH-1:0]   mul_mq;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_acc;
    logic [WIDTH-1:0]   div_mq;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   mq_d;
    logic [WIDTH-1:0]   acc_fin_d;
    logic [WIDTH-1:0]   mq_fin_d;

    // Datapath step: shift-add multiply or restoring divide, selected per op
    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set, then shift right
        mul_sum   = mq_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
        mul_acc   = mul_sum[WIDTH:1];
        mul_mq    = {mul_sum[0], mq_q[WIDTH-1:1]};

        // Divide: bring in next dividend bit, subtract divisor if it fits
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        // Difference is always below the divisor, so WIDTH bits hold it exactly
        div_acc   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
        div_mq    = {mq_q[WIDTH-2:0], div_ge};

        acc_d     = is_div_q ? div_acc : mul_acc;
        mq_d      = is_div_q ? div_mq  : mul_mq;

        // Sign correction of the finished magnitude result
        prod      = {mul_acc, mul_mq};
        prod_fix  = neg_lo_q ? (-prod) : prod;
        if (is_div_q) begin
            acc_fin_d = neg_hi_q ? (-div_acc) : div_acc;
            mq_fin_d  = neg_lo_q ? (-div_mq)  : div_mq;
        end else begin
            acc_fin_d = prod_fix[2*WIDTH-1:WIDTH];
            mq_fin_d  = prod_fix[WIDTH-1:0];
        end
    end

    // Control FSM with all registered outputs and working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Direct writes land even when a start arrives alongside them
                    if (hi_we_i) hi_q <= wdata_i;
                    if (lo_we_i) lo_q <= wdata_i;
                    if (start_i) begin
                        if (start_div0) begin
                            zero_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            zero_q   <= 1'b0;
                            is_div_q <= op_div;
                            neg_lo_q <= a_neg ^ b_neg;
                            neg_hi_q <= op_div & a_neg;
                            acc_q    <= '0;
                            mq_q     <= op_div ? a_mag : b_mag;
                            opnd_q   <= op_div ? b_mag : a_mag;
                            cnt_q    <= CW'(WIDTH);
                            busy_q   <= 1'b1;
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        acc_q   <= acc_fin_d;
                        mq_q    <= mq_fin_d;
                        busy_q  <= 1'b0;
                        state_q <= FIN;
                    end else begin
                        acc_q <= acc_d;
                        mq_q  <= mq_d;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    if (zero_q) begin
                        dz_q <= 1'b1;
                    end else begin
                        hi_q <= acc_q;
                        lo_q <= mq_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq at WIDTH=32: fixed vectors, corner-case sequences,
// and random operations compared against an arithmetic reference model.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .hi_we_i    (hi_we),
        .lo_we_i    (lo_we),
        .wdata_i    (wdata),
        .busy_o     (busy),
        .done_o     (done),
        .div_zero_o (dz),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {div_zero, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] ch,
                                          input logic [31:0] cl);
        longint      sx, sy;
        logic [63:0] ux, uy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (o[1] && y == 32'd0) return {1'b1, ch, cl};
        case (o)
            2'd0: begin p = 64'(sx * sy); return {1'b0, p}; end
            2'd1: begin p = ux * uy;      return {1'b0, p}; end
            2'd2: begin q = 64'(sx / sy); r = 64'(sx % sy); return {1'b0, r[31:0], q[31:0]}; end
            default: begin q = ux / uy; r = ux % uy; return {1'b0, r[31:0], q[31:0]}; end
        endcase
    endfunction

    // mode 0: plain op; 1: second start + hi_we injected mid-run; 2: hi_we/lo_we with start
    task automatic run_op(input string nm, input logic [1:0] ov, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                          input logic edz, input int mode);
        int          done_j = -1;
        int          ndone = 0;
        int          nbusy = 0;
        int          stray_dz = 0;
        logic        dz_seen = 1'b0;
        logic        hold_ok = 1'b1;
        logic [31:0] h0 = '0;
        logic [31:0] l0 = '0;
        @(negedge clk);
        op = ov; a = av; b = bv; start = 1'b1;
        if (mode == 2) begin
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
        end
        for (int j = 0; j < W + 4; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
                h0 = hi; l0 = lo;
                if (mode == 2) chk({nm, "/wr_with_start"}, {hi, lo}, {2{32'hA5A5A5A5}});
            end
            if (mode == 1 && j == 4) begin
                start = 1'b1; op = 2'd1; a = 32'h7; b = 32'h9;
                hi_we = 1'b1; wdata = 32'hDEADBEEF;
            end
            if (mode == 1 && j == 5) begin
                start = 1'b0; hi_we = 1'b0;
            end
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_j < 0) begin
                    done_j  = j;
                    dz_seen = dz;
                end
            end else if (dz) begin
                stray_dz++;
            end
            if (done_j < 0 && (hi !== h0 || lo !== l0)) hold_ok = 1'b0;
        end
        chk({nm, "/latency"}, 64'(done_j), edz ? 64'd1 : 64'(W + 1));
        chk({nm, "/done_count"}, 64'(ndone), 64'd1);
        chk({nm, "/busy_cycles"}, 64'(nbusy), edz ? 64'd0 : 64'(W));
        chk({nm, "/hi"}, {32'd0, hi}, {32'd0, eh});
        chk({nm, "/lo"}, {32'd0, lo}, {32'd0, el});
        chk({nm, "/div_zero"}, {63'd0, dz_seen}, {63'd0, edz});
        chk({nm, "/stray_dz"}, 64'(stray_dz), 64'd0);
        chk({nm, "/hilo_hold"}, {63'd0, hold_ok}, 64'd1);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic wr(input logic sel_hi, input logic [31:0] d);
        @(negedge clk);
        wdata = d;
        if (sel_hi) hi_we = 1'b1; else lo_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        if (sel_hi) begin
            chk("mthi", {32'd0, hi}, {32'd0, d});
            m_hi = d;
        end else begin
            chk("mtlo", {32'd0, lo}, {32'd0, d});
            m_lo = d;
        end
    endtask

    initial begin
        logic [64:0] r;
        logic [1:0]  ov;
        logic [31:0] av, bv;
        int          nd;

        tbl[0] = '{"smul_neg3x5",    2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[1] = '{"umul_max_x2",    2'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        tbl[2] = '{"sdiv_neg7_2",    2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{"sdiv_min_m1",    2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[4] = '{"udiv_100_7",     2'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        tbl[5] = '{"smul_min_min",   2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[6] = '{"sdiv_7_neg2",    2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tbl[7] = '{"umul_zero",      2'd1, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000};
        tbl[8] = '{"udiv_max_1",     2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        tbl[9] = '{"smul_max_m1",    2'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst/busy", {63'd0, busy}, 64'd0);
        chk("rst/done", {63'd0, done}, 64'd0);
        chk("rst/div_zero", {63'd0, dz}, 64'd0);
        chk("rst/hi", {32'd0, hi}, 64'd0);
        chk("rst/lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;

        // Fixed vectors
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, 1'b0, 0);
        end

        // Divide by zero with preloaded HI
        wr(1'b1, 32'h12345678);
        run_op("udiv_by_zero", 2'd3, 32'd99, 32'd0, 32'h12345678, m_lo, 1'b1, 0);
        run_op("sdiv_by_zero", 2'd2, 32'h80000000, 32'd0, m_hi, m_lo, 1'b1, 0);

        // Start and HI write during a running op are ignored
        run_op("inject_mid_run", 2'd0, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1);

        // Direct writes in the same cycle as start; result overwrites them
        run_op("wr_then_result", 2'd1, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 2);

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ov = 2'($urandom_range(0, 3));
            av = $urandom;
            bv = $urandom >> $urandom_range(0, 31);
            if (ov[1] && $urandom_range(0, 7) == 0) bv = 32'd0;
            r = model(ov, av, bv, m_hi, m_lo);
            run_op($sformatf("rnd%0d_op%0d", i, ov), ov, av, bv, r[63:32], r[31:0], r[64], 0);
        end

        // Asynchronous reset in the middle of a divide
        wr(1'b1, 32'h11111111);
        wr(1'b0, 32'h22222222);
        @(negedge clk);
        op = 2'd2; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort/busy_before", {63'd0, busy}, 64'd1);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort/busy", {63'd0, busy}, 64'd0);
        chk("abort/hilo", {hi, lo}, 64'd0);
        chk("abort/done", {63'd0, done}, 64'd0);
        nd = 0;
        for (int j = 0; j < W + 4; j++) begin
            @(negedge clk);
            if (j == 3) rst_n = 1'b1;
            if (done) nd++;
        end
        chk("abort/no_done", 64'(nd), 64'd0);
        m_hi = '0;
        m_lo = '0;
        run_op("after_reset_3x4", 2'd0, 32'd3, 32'd4, 32'd0, 32'h0000000C, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state SHALL change on rising edge only.
REQ-003 reset  input  1  asynchronous, active-low reset; the block SHALL enter reset immediately when reset goes low, independent of clk.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 signed mult, 01 unsigned mult, 10 signed div, 11 unsigned div; sampled with start.
REQ-006 a  input  WIDTH  multiplicand / dividend; sampled with start.
REQ-007 b  input  WIDTH  multiplier / divisor; sampled with start.
REQ-008 hi_we  input  1  direct HI write (mthi).
REQ-009 lo_we  input  1  direct LO write (mtlo).
REQ-010 wdata  input  WIDTH  data for hi_we/lo_we.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 div_zero  output  1  one-cycle pulse, coincident with done, for division by zero.
REQ-014 hi  output  WIDTH  HI register: product upper half / remainder.
REQ-015 lo  output  WIDTH  LO register: product lower half / quotient.

Function
REQ-016 FSM states SHALL be IDLE, RUN, FIN; FIN SHALL always return to IDLE after one cycle.
REQ-017 IDLE, start=1, divisor nonzero or op=0x: the block SHALL latch operands, load the iteration counter with WIDTH, and go to RUN.
REQ-018 RUN: the block SHALL perform exactly one iteration per cycle (shift-add multiply, or restoring divide step) on operand magnitudes and decrement the counter; at counter 1 it SHALL go to FIN.
REQ-019 Latency: for start accepted at edge k, busy SHALL be high from k+1 through k+WIDTH; hi/lo update and done SHALL assert at edge k+WIDTH+1.
REQ-020 Signed ops: sign correction SHALL be applied at the transition into FIN; quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-021 Multiply: {hi,lo} SHALL be the full 2*WIDTH product; division: lo SHALL hold the quotient and hi the remainder.
REQ-022 Signed MIN / -1 SHALL yield lo=MIN, hi=0, with no flag.
REQ-023 Division with b=0 in IDLE: the block SHALL go directly to FIN; done and div_zero SHALL pulse at edge k+1, busy SHALL stay low, and hi/lo SHALL be unchanged.
REQ-024 start while busy or in FIN SHALL be ignored, with no queuing.
REQ-025 hi_we/lo_we in IDLE SHALL load wdata into hi/lo at the next edge; in RUN/FIN they SHALL be ignored.
REQ-026 hi_we/lo_we with start in the same IDLE cycle: the write SHALL take effect, start SHALL be accepted, and the later result SHALL overwrite.
REQ-027 hi and lo SHALL change only per REQ-019, REQ-025 or reset; intermediate values SHALL stay in internal registers.
REQ-028 The block SHALL use no combinational path from inputs to outputs.

Reset
REQ-029 On reset low: state SHALL go to IDLE; busy, done and div_zero SHALL be 0; hi, lo, counter and internal registers SHALL be 0.
REQ-030 Reset asserted mid-RUN SHALL abort the operation, with no done pulse; the first start after reset release SHALL be accepted normally.

Verification (WIDTH=32)
REQ-031 op=00, a=FFFFFFFD, b=00000005 -> done at k+33; hi=FFFFFFFF, lo=FFFFFFF1; busy high for exactly 32 cycles.
REQ-032 op=01, a=FFFFFFFF, b=00000002 -> hi=00000001, lo=FFFFFFFE; op=10, a=FFFFFFF9, b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-033 op=10, a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, div_zero=0.
REQ-034 op=11, b=0, with hi=12345678 preloaded via hi_we -> done and div_zero pulse at k+1, busy=0, hi=12345678 unchanged.
REQ-035 Second start and hi_we at cycle k+5 of a running op -> both ignored; single done at k+33 with the first op's result.
REQ-036 reset low at k+10 of a divide -> immediate busy=0, hi=lo=0, no done; new op=00 3*4 after release -> lo=0000000C, hi=0.
